// File: rtl/mem_map_pkg.sv
// Shared encodings for the IMEM/DMEM write arbiter: memory regions, access sizes,
// arbiter states and a region decode helper.
package mem_map_pkg;

  localparam logic [3:0] REG_DMEM = 4'h1;
  localparam logic [3:0] REG_IMEM = 4'h2;
  localparam logic [3:0] REG_BOTH = 4'h3;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CORE = 2'd2
  } arb_state_e;

  // Returns {imem_hit, dmem_hit}; 2'b00 means the region is not writable.
  function automatic logic [1:0] region_hit(input logic [3:0] region);
    unique case (region)
      REG_DMEM: region_hit = 2'b01;
      REG_IMEM: region_hit = 2'b10;
      REG_BOTH: region_hit = 2'b11;
      default:  region_hit = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_write_arbiter_if.sv
// Request/response bundle between the store path, the UART loader and the shared
// IMEM/DMEM write port.
interface mem_write_arbiter_if #(
  parameter int unsigned MEM_AW = 14
);
  logic              core_valid;
  logic              core_ready;
  logic [31:0]       core_addr;
  logic [31:0]       core_data;
  logic [1:0]        core_size;
  logic              ld_valid;
  logic              ld_ready;
  logic              ld_lock;
  logic [31:0]       ld_addr;
  logic [31:0]       ld_data;
  logic [1:0]        ld_size;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic [3:0]        dmem_we;
  logic [3:0]        imem_we;
  logic              drop_err;

  modport slave (
    input  core_valid, core_addr, core_data, core_size,
    input  ld_valid, ld_lock, ld_addr, ld_data, ld_size,
    output core_ready, ld_ready,
    output mem_addr, mem_din, dmem_we, imem_we, drop_err
  );

  modport master (
    output core_valid, core_addr, core_data, core_size,
    output ld_valid, ld_lock, ld_addr, ld_data, ld_size,
    input  core_ready, ld_ready,
    input  mem_addr, mem_din, dmem_we, imem_we, drop_err
  );
endinterface

// File: rtl/mem_lane_enc.sv
// Byte-lane encoder: access size and low address bits -> write mask, replicated data,
// illegal flag. MEM_WRITE_ARBITER_ALIGN_CHECK_EN flags misaligned half/word accesses.
module mem_lane_enc
  import mem_map_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] data,
  output logic [3:0]  we,
  output logic [31:0] din,
  output logic        illegal
);

  always_comb begin
    we      = 4'b0000;
    din     = data;
    illegal = 1'b0;
    unique case (size)
      SZ_B: begin
        we  = 4'b0001 << addr_lo;
        din = {4{data[7:0]}};
      end
      SZ_H: begin
        we  = addr_lo[1] ? 4'b1100 : 4'b0011;
        din = {2{data[15:0]}};
`ifdef MEM_WRITE_ARBITER_ALIGN_CHECK_EN
        illegal = addr_lo[0];
`endif
      end
      SZ_W: begin
        we = 4'b1111;
`ifdef MEM_WRITE_ARBITER_ALIGN_CHECK_EN
        illegal = |addr_lo;
`endif
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_write_arbiter.sv
// Arbitrates core stores and loader writes onto one registered IMEM/DMEM byte-write port.
// Define MEM_WRITE_ARBITER_ALIGN_CHECK_EN to drop misaligned half/word requests.
module mem_write_arbiter
  import mem_map_pkg::*;
#(
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned MEM_AW    = 14
) (
  input  logic                clk,
  input  logic                rst,
  mem_write_arbiter_if.slave  bus
);

  localparam logic [7:0] MaxCnt = 8'(MAX_BURST);

  arb_state_e        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [MEM_AW-1:0] mem_addr_q;
  logic [31:0]       mem_din_q;
  logic [3:0]        dmem_we_q, imem_we_q;
  logic              drop_err_q;

  logic        core_gnt, ld_gnt, accept;
  logic [31:0] sel_addr, sel_data;
  logic [1:0]  sel_size;
  logic [3:0]  lane_we;
  logic [31:0] lane_din;
  logic        lane_illegal;
  logic [1:0]  hit;
  logic        drop;
  logic        unused_addr;

  always_comb begin
    core_gnt = 1'b0;
    ld_gnt   = 1'b0;
    state_d  = state_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.core_valid) begin
          core_gnt = 1'b1;
        end else if (bus.ld_valid) begin
          ld_gnt = 1'b1;
          if (bus.ld_lock) state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (bus.ld_valid)        ld_gnt   = 1'b1;
        else if (bus.core_valid) core_gnt = 1'b1;
        // Count only loader grants that made a waiting core request wait longer.
        if (!bus.core_valid)  cnt_d = 8'd0;
        else if (ld_gnt)      cnt_d = (cnt_q == MaxCnt) ? cnt_q : cnt_q + 8'd1;
        if (!bus.ld_lock) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end else if (bus.core_valid && cnt_d == MaxCnt) begin
          state_d = S_CORE;
        end
      end
      S_CORE: begin
        core_gnt = bus.core_valid;
        state_d  = bus.ld_lock ? S_LOAD : S_IDLE;
        cnt_d    = 8'd0;
      end
      default: state_d = S_IDLE;
    endcase
    // Nothing is accepted while reset is held, so no write can leak out of it.
    if (rst) begin
      core_gnt = 1'b0;
      ld_gnt   = 1'b0;
    end
  end

  assign accept   = core_gnt | ld_gnt;
  assign sel_addr = core_gnt ? bus.core_addr : bus.ld_addr;
  assign sel_data = core_gnt ? bus.core_data : bus.ld_data;
  assign sel_size = core_gnt ? bus.core_size : bus.ld_size;

  mem_lane_enc u_lane_enc (
    .addr_lo (sel_addr[1:0]),
    .size    (sel_size),
    .data    (sel_data),
    .we      (lane_we),
    .din     (lane_din),
    .illegal (lane_illegal)
  );

  assign hit  = region_hit(sel_addr[31:28]);
  assign drop = lane_illegal | (hit == 2'b00);

  assign unused_addr = ^sel_addr[27:MEM_AW+2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      dmem_we_q  <= 4'b0000;
      imem_we_q  <= 4'b0000;
      drop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dmem_we_q  <= (accept && !drop && hit[0]) ? lane_we : 4'b0000;
      imem_we_q  <= (accept && !drop && hit[1]) ? lane_we : 4'b0000;
      drop_err_q <= accept & drop;
      if (accept) begin
        mem_addr_q <= sel_addr[MEM_AW+1:2];
        mem_din_q  <= lane_din;
      end
    end
  end

  assign bus.core_ready = core_gnt;
  assign bus.ld_ready   = ld_gnt;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_din    = mem_din_q;
  assign bus.dmem_we    = dmem_we_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.drop_err   = drop_err_q;

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Directed bench for mem_write_arbiter: single-cycle vector table plus burst, lock-release
// and mid-burst reset sequences.
module tb_mem_write_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mem_write_arbiter_if #(.MEM_AW(14)) bus ();

  mem_write_arbiter #(
    .MAX_BURST (8),
    .MEM_AW    (14)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    string       nm;
    logic        cv;
    logic [31:0] ca;
    logic [31:0] cd;
    logic [1:0]  cs;
    logic        lv;
    logic [31:0] la;
    logic [31:0] ld;
    logic [1:0]  ls;
    logic        e_cr;
    logic        e_lr;
    logic [3:0]  e_dwe;
    logic [3:0]  e_iwe;
    logic        e_drop;
    logic        e_chk;
    logic [13:0] e_addr;
    logic [31:0] e_din;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.core_valid = 1'b0;
    bus.core_addr  = 32'h0;
    bus.core_data  = 32'h0;
    bus.core_size  = 2'b00;
    bus.ld_valid   = 1'b0;
    bus.ld_lock    = 1'b0;
    bus.ld_addr    = 32'h0;
    bus.ld_data    = 32'h0;
    bus.ld_size    = 2'b00;
  endtask

  task automatic chk_we(input string name, input logic [3:0] dwe, input logic [3:0] iwe,
                        input logic drop);
    chk({name, ".dmem_we"}, 32'(bus.dmem_we), 32'(dwe));
    chk({name, ".imem_we"}, 32'(bus.imem_we), 32'(iwe));
    chk({name, ".drop_err"}, 32'(bus.drop_err), 32'(drop));
  endtask

  int   ld_cnt;
  int   core_at;
  bit   resumed;
  logic got_core, got_ld;

  initial begin
    //        name         cv    core_addr      core_data      cs     lv    ld_addr        ld_data        ls     cr    lr    dwe      iwe      drp   chk   addr      din
    vecs[0] = '{"sb_dmem",   1'b1, 32'h1000_0006, 32'h0000_00AB, 2'b00, 1'b0, 32'h0,         32'h0,         2'b00, 1'b1, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1, 14'h1,    32'hABAB_ABAB};
    vecs[1] = '{"bad_region",1'b1, 32'h4000_0000, 32'h0000_0055, 2'b00, 1'b0, 32'h0,         32'h0,         2'b00, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 14'h0,    32'h0};
    vecs[2] = '{"sh_imem",   1'b1, 32'h2000_0002, 32'h1234_BEEF, 2'b01, 1'b0, 32'h0,         32'h0,         2'b00, 1'b1, 1'b0, 4'b0000, 4'b1100, 1'b0, 1'b1, 14'h0,    32'hBEEF_BEEF};
    vecs[3] = '{"size_rsv",  1'b1, 32'h1000_0000, 32'h1111_2222, 2'b11, 1'b0, 32'h0,         32'h0,         2'b00, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 14'h0,    32'h0};
    vecs[4] = '{"sw_both",   1'b1, 32'h3000_000C, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0,         32'h0,         2'b00, 1'b1, 1'b0, 4'b1111, 4'b1111, 1'b0, 1'b1, 14'h3,    32'hDEAD_BEEF};
    vecs[5] = '{"ld_nolock", 1'b0, 32'h0,         32'h0,         2'b00, 1'b1, 32'h1000_0100, 32'h0102_0304, 2'b10, 1'b0, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b1, 14'h40,   32'h0102_0304};
    vecs[6] = '{"core_prio", 1'b1, 32'h1000_0003, 32'h0000_007F, 2'b00, 1'b1, 32'h2000_0000, 32'h5555_5555, 2'b10, 1'b1, 1'b0, 4'b1000, 4'b0000, 1'b0, 1'b1, 14'h0,    32'h7F7F_7F7F};
`ifdef MEM_WRITE_ARBITER_ALIGN_CHECK_EN
    vecs[7] = '{"sh_misal",  1'b1, 32'h1000_0001, 32'h0000_00CD, 2'b01, 1'b0, 32'h0,         32'h0,         2'b00, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 14'h0,    32'h0};
    vecs[8] = '{"sw_misal",  1'b1, 32'h1000_0002, 32'h89AB_CDEF, 2'b10, 1'b0, 32'h0,         32'h0,         2'b00, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 14'h0,    32'h0};
`else
    vecs[7] = '{"sh_misal",  1'b1, 32'h1000_0001, 32'h0000_00CD, 2'b01, 1'b0, 32'h0,         32'h0,         2'b00, 1'b1, 1'b0, 4'b0011, 4'b0000, 1'b0, 1'b1, 14'h0,    32'h00CD_00CD};
    vecs[8] = '{"sw_misal",  1'b1, 32'h1000_0002, 32'h89AB_CDEF, 2'b10, 1'b0, 32'h0,         32'h0,         2'b00, 1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b1, 14'h0,    32'h89AB_CDEF};
`endif
    vecs[9] = '{"no_req",    1'b0, 32'h0,         32'h0,         2'b00, 1'b0, 32'h0,         32'h0,         2'b00, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 14'h0,    32'h0};

    // Reset: a request presented while reset is held never reaches the memories.
    idle_inputs();
    bus.core_valid = 1'b1;
    bus.core_addr  = 32'h1000_0000;
    bus.core_size  = 2'b10;
    cyc();
    cyc();
    chk_we("reset", 4'b0000, 4'b0000, 1'b0);
    chk("reset.mem_addr", 32'(bus.mem_addr), 32'h0);
    chk("reset.mem_din", bus.mem_din, 32'h0);
    idle_inputs();
    rst = 1'b0;
    cyc();
    chk_we("post_reset", 4'b0000, 4'b0000, 1'b0);

    for (int i = 0; i < 10; i++) begin
      bus.core_valid = vecs[i].cv;
      bus.core_addr  = vecs[i].ca;
      bus.core_data  = vecs[i].cd;
      bus.core_size  = vecs[i].cs;
      bus.ld_valid   = vecs[i].lv;
      bus.ld_lock    = 1'b0;
      bus.ld_addr    = vecs[i].la;
      bus.ld_data    = vecs[i].ld;
      bus.ld_size    = vecs[i].ls;
      #1;
      chk({vecs[i].nm, ".core_ready"}, 32'(bus.core_ready), 32'(vecs[i].e_cr));
      chk({vecs[i].nm, ".ld_ready"}, 32'(bus.ld_ready), 32'(vecs[i].e_lr));
      cyc();
      chk_we(vecs[i].nm, vecs[i].e_dwe, vecs[i].e_iwe, vecs[i].e_drop);
      if (vecs[i].e_chk) begin
        chk({vecs[i].nm, ".mem_addr"}, 32'(bus.mem_addr), 32'(vecs[i].e_addr));
        chk({vecs[i].nm, ".mem_din"}, bus.mem_din, vecs[i].e_din);
      end
    end
    idle_inputs();
    cyc();

    // Locked loader word write from idle enters the loader burst.
    bus.ld_valid = 1'b1;
    bus.ld_lock  = 1'b1;
    bus.ld_addr  = 32'h3000_0010;
    bus.ld_data  = 32'hCAFE_F00D;
    bus.ld_size  = 2'b10;
    #1;
    chk("lock_grant.ld_ready", 32'(bus.ld_ready), 32'h1);
    cyc();
    chk_we("lock_grant", 4'b1111, 4'b1111, 1'b0);
    chk("lock_grant.mem_addr", 32'(bus.mem_addr), 32'h4);

    // Both requesting under lock: MAX_BURST loader grants, one core grant, loader again.
    bus.ld_addr    = 32'h2000_0000;
    bus.core_valid = 1'b1;
    bus.core_addr  = 32'h1000_0020;
    bus.core_data  = 32'hC0DE_0000;
    bus.core_size  = 2'b10;
    ld_cnt  = 0;
    core_at = -1;
    resumed = 1'b0;
    for (int i = 0; i < 20 && !resumed; i++) begin
      #1;
      got_core = bus.core_ready;
      got_ld   = bus.ld_ready;
      chk("burst.one_accept", 32'(got_core & got_ld), 32'h0);
      if (got_ld && core_at >= 0) resumed = 1'b1;
      if (got_ld && core_at < 0)  ld_cnt++;
      if (got_core) core_at = ld_cnt;
      cyc();
      if (got_core) begin
        chk_we("burst.core_wr", 4'b1111, 4'b0000, 1'b0);
        chk("burst.core_addr", 32'(bus.mem_addr), 32'h8);
        chk("burst.core_din", bus.mem_din, 32'hC0DE_0000);
        bus.core_valid = 1'b0;
      end else if (got_ld) begin
        chk_we("burst.ld_wr", 4'b0000, 4'b1111, 1'b0);
      end
    end
    chk("burst.ld_before_core", 32'(ld_cnt), 32'd8);
    chk("burst.core_granted", 32'(core_at >= 0), 32'h1);
    chk("burst.loader_resumed", 32'(resumed), 32'h1);

    // Lock released with only the core requesting, then core wins a tie again (idle).
    bus.ld_valid   = 1'b0;
    bus.ld_lock    = 1'b0;
    bus.core_valid = 1'b1;
    bus.core_addr  = 32'h2000_0001;
    bus.core_data  = 32'h0000_0011;
    bus.core_size  = 2'b00;
    #1;
    chk("unlock.core_ready", 32'(bus.core_ready), 32'h1);
    cyc();
    chk_we("unlock", 4'b0000, 4'b0010, 1'b0);
    chk("unlock.mem_din", bus.mem_din, 32'h1111_1111);
    bus.ld_valid = 1'b1;
    #1;
    chk("idle_tie.core_ready", 32'(bus.core_ready), 32'h1);
    chk("idle_tie.ld_ready", 32'(bus.ld_ready), 32'h0);
    cyc();
    idle_inputs();
    cyc();

    // Reset mid-burst, after an accept: outputs clear at once and the write never lands.
    bus.ld_valid = 1'b1;
    bus.ld_lock  = 1'b1;
    bus.ld_addr  = 32'h2000_0040;
    bus.ld_data  = 32'hAAAA_5555;
    bus.ld_size  = 2'b10;
    cyc();
    chk_we("rst_burst.first", 4'b0000, 4'b1111, 1'b0);
    bus.ld_addr = 32'h2000_0044;
    #1;
    chk("rst_burst.ld_ready", 32'(bus.ld_ready), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk_we("rst_burst.async", 4'b0000, 4'b0000, 1'b0);
    chk("rst_burst.mem_addr", 32'(bus.mem_addr), 32'h0);
    chk("rst_burst.mem_din", bus.mem_din, 32'h0);
    cyc();
    chk_we("rst_burst.held", 4'b0000, 4'b0000, 1'b0);
    idle_inputs();
    rst = 1'b0;
    cyc();
    chk_we("rst_burst.after", 4'b0000, 4'b0000, 1'b0);
    bus.ld_valid   = 1'b1;
    bus.ld_lock    = 1'b1;
    bus.ld_addr    = 32'h2000_0000;
    bus.ld_size    = 2'b10;
    bus.core_valid = 1'b1;
    bus.core_addr  = 32'h1000_0000;
    bus.core_data  = 32'h0000_0042;
    bus.core_size  = 2'b00;
    #1;
    chk("rst_idle.core_ready", 32'(bus.core_ready), 32'h1);
    chk("rst_idle.ld_ready", 32'(bus.ld_ready), 32'h0);
    cyc();
    chk_we("rst_idle", 4'b0001, 4'b0000, 1'b0);
    idle_inputs();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
